card_pos_sweep: RTL and testbench

//   Streams the screen position of every card slot on a configurable ROWS x COLS board, one slot per beat.

---
 rtl/card_pos_pkg.sv | 25 ++
 rtl/card_pos_hit.sv | 90 +++++++++
 rtl/card_pos_sweep.sv | 158 +++++++++++++++
 tb/tb_card_pos_sweep.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pos_pkg.sv
// Shared types and default geometry for the card position sweep.
// Optional pointer hit test is enabled by defining CARD_POS_HIT_EN.
package card_pos_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned DEF_COLS    = 4;
   localparam int unsigned DEF_ROWS    = 4;
   localparam int unsigned DEF_COORD_W = 10;
   localparam int unsigned DEF_IDX_W   = 5;
   localparam int unsigned DEF_X0      = 60;
   localparam int unsigned DEF_Y0      = 121;
   localparam int unsigned DEF_PITCH_X = 100;
   localparam int unsigned DEF_PITCH_Y = 100;
   localparam int unsigned DEF_CARD_W  = 80;
   localparam int unsigned DEF_CARD_H  = 80;

   function automatic int unsigned num_slots(input int unsigned cols, input int unsigned rows);
      return cols * rows;
   endfunction

endpackage

// File: rtl/card_pos_hit.sv
// Pointer-in-card box test with first-match latch; result published when the sweep ends.
// Only instantiated when CARD_POS_HIT_EN is defined.
module card_pos_hit
   import card_pos_pkg::*;
#(
   parameter int unsigned COORD_W = DEF_COORD_W,
   parameter int unsigned IDX_W   = DEF_IDX_W,
   parameter int unsigned CARD_W  = DEF_CARD_W,
   parameter int unsigned CARD_H  = DEF_CARD_H
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear_i,
   input  logic               xfer_i,
   input  logic               last_i,
   input  logic [COORD_W-1:0] ptr_x_i,
   input  logic [COORD_W-1:0] ptr_y_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   input  logic [IDX_W-1:0]   slot_i,
   output logic               hit_valid_o,
   output logic [IDX_W-1:0]   hit_slot_o
);

   localparam logic [COORD_W:0] CARD_W_EXT = (COORD_W+1)'(CARD_W);
   localparam logic [COORD_W:0] CARD_H_EXT = (COORD_W+1)'(CARD_H);

   logic [COORD_W-1:0] px_q, py_q;
   logic               found_q, found_d;
   logic [IDX_W-1:0]   fslot_q, fslot_d;
   logic               hv_q, hv_d;
   logic [IDX_W-1:0]   hs_q, hs_d;
   logic [COORD_W:0]   px_w, py_w, x_lo, y_lo, x_hi, y_hi;
   logic               in_box;

   // One extra bit so x+CARD_W cannot wrap at the screen edge.
   assign px_w   = {1'b0, px_q};
   assign py_w   = {1'b0, py_q};
   assign x_lo   = {1'b0, x_i};
   assign y_lo   = {1'b0, y_i};
   assign x_hi   = x_lo + CARD_W_EXT;
   assign y_hi   = y_lo + CARD_H_EXT;
   assign in_box = (px_w >= x_lo) && (px_w < x_hi) && (py_w >= y_lo) && (py_w < y_hi);

   always_comb begin
      found_d = found_q;
      fslot_d = fslot_q;
      hv_d    = hv_q;
      hs_d    = hs_q;
      if (clear_i) begin
         found_d = 1'b0;
         fslot_d = '0;
         hv_d    = 1'b0;
         hs_d    = '0;
      end else if (xfer_i) begin
         if (!found_q && in_box) begin
            found_d = 1'b1;
            fslot_d = slot_i;
         end
         if (last_i) begin
            hv_d = found_q || in_box;
            hs_d = found_q ? fslot_q : (in_box ? slot_i : '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q    <= '0;
         py_q    <= '0;
         found_q <= 1'b0;
         fslot_q <= '0;
         hv_q    <= 1'b0;
         hs_q    <= '0;
      end else begin
         if (clear_i) begin
            px_q <= ptr_x_i;
            py_q <= ptr_y_i;
         end
         found_q <= found_d;
         fslot_q <= fslot_d;
         hv_q    <= hv_d;
         hs_q    <= hs_d;
      end
   end

   assign hit_valid_o = hv_q;
   assign hit_slot_o  = hs_q;

endmodule

// File: rtl/card_pos_sweep.sv
// Streams (slot, x, y) for every card slot, column-major, over a valid/ready handshake.
// Define CARD_POS_HIT_EN to add the pointer hit-test ports and logic.
module card_pos_sweep
   import card_pos_pkg::*;
#(
   parameter int unsigned COLS    = DEF_COLS,
   parameter int unsigned ROWS    = DEF_ROWS,
   parameter int unsigned COORD_W = DEF_COORD_W,
   parameter int unsigned IDX_W   = DEF_IDX_W,
   parameter int unsigned X0      = DEF_X0,
   parameter int unsigned Y0      = DEF_Y0,
   parameter int unsigned PITCH_X = DEF_PITCH_X,
   parameter int unsigned PITCH_Y = DEF_PITCH_Y,
   parameter int unsigned CARD_W  = DEF_CARD_W,
   parameter int unsigned CARD_H  = DEF_CARD_H
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_slot,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y
`ifdef CARD_POS_HIT_EN
   ,
   input  logic [COORD_W-1:0] ptr_x,
   input  logic [COORD_W-1:0] ptr_y,
   output logic               hit_valid,
   output logic [IDX_W-1:0]   hit_slot
`endif
);

   localparam int unsigned NUM_SLOTS = num_slots(COLS, ROWS);
   localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [COORD_W-1:0] X0_C      = COORD_W'(X0);
   localparam logic [COORD_W-1:0] Y0_C      = COORD_W'(Y0);
   localparam logic [COORD_W-1:0] PITCH_X_C = COORD_W'(PITCH_X);
   localparam logic [COORD_W-1:0] PITCH_Y_C = COORD_W'(PITCH_Y);
   localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [IDX_W-1:0]   SLOT_LAST = IDX_W'(NUM_SLOTS);

   if (X0 + (COLS - 1) * PITCH_X + CARD_W >= (1 << COORD_W)) begin : g_chk_x
      $error("card_pos_sweep: x range exceeds COORD_W");
   end
   if (Y0 + (ROWS - 1) * PITCH_Y + CARD_H >= (1 << COORD_W)) begin : g_chk_y
      $error("card_pos_sweep: y range exceeds COORD_W");
   end
   if (NUM_SLOTS >= (1 << IDX_W)) begin : g_chk_idx
      $error("card_pos_sweep: IDX_W too narrow for NUM_SLOTS");
   end

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [IDX_W-1:0]   slot_q, slot_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               done_q, done_d;
   logic               start_acc, xfer, last_xfer;

   assign start_acc = (state_q == IDLE) && start;
   // abort wins over a transfer presented in the same cycle
   assign xfer      = (state_q == RUN) && out_ready && !abort;
   assign last_xfer = xfer && (slot_q == SLOT_LAST);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      slot_d  = slot_q;
      x_d     = x_q;
      y_d     = y_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_acc) begin
               state_d = RUN;
               row_d   = '0;
               slot_d  = IDX_W'(1);
               x_d     = X0_C;
               y_d     = Y0_C;
            end
         end
         RUN: begin
            if (abort || last_xfer) begin
               state_d = IDLE;
               done_d  = last_xfer;
               row_d   = '0;
               slot_d  = '0;
               x_d     = '0;
               y_d     = '0;
            end else if (xfer) begin
               slot_d = slot_q + IDX_W'(1);
               if (row_q != ROW_LAST) begin
                  row_d = row_q + ROW_W'(1);
                  y_d   = y_q + PITCH_Y_C;
               end else begin
                  row_d = '0;
                  y_d   = Y0_C;
                  x_d   = x_q + PITCH_X_C;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         slot_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         slot_q  <= slot_d;
         x_q     <= x_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == RUN);
   assign done      = done_q;
   assign out_slot  = slot_q;
   assign out_x     = x_q;
   assign out_y     = y_q;

`ifdef CARD_POS_HIT_EN
   card_pos_hit #(
      .COORD_W (COORD_W),
      .IDX_W   (IDX_W),
      .CARD_W  (CARD_W),
      .CARD_H  (CARD_H)
   ) u_hit (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (start_acc),
      .xfer_i      (xfer),
      .last_i      (last_xfer),
      .ptr_x_i     (ptr_x),
      .ptr_y_i     (ptr_y),
      .x_i         (x_q),
      .y_i         (y_q),
      .slot_i      (slot_q),
      .hit_valid_o (hit_valid),
      .hit_slot_o  (hit_slot)
   );
`endif

endmodule

// File: tb/tb_card_pos_sweep.sv
// Scoreboard bench for card_pos_sweep: 4x4 default instance plus a 2x3 instance.
// Hit-test checks run only when CARD_POS_HIT_EN is defined.
module tb_card_pos_sweep;

   typedef struct {
      int slot;
      int x;
      int y;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, abort, out_ready, busy, done, out_valid;
   logic [4:0] out_slot;
   logic [9:0] out_x, out_y;
   logic       start2, abort2, out_ready2, busy2, done2, out_valid2;
   logic [4:0] out_slot2;
   logic [9:0] out_x2, out_y2;
`ifdef CARD_POS_HIT_EN
   logic [9:0] ptr_x, ptr_y, ptr_x2, ptr_y2;
   logic       hit_valid, hit_valid2;
   logic [4:0] hit_slot, hit_slot2;
`endif

   int    total = 0, passed = 0;
   int    done_cnt = 0, done_cnt2 = 0, exp_done = 0;
   beat_t exp_q[$];
   beat_t exp2_q[$];

   card_pos_sweep #(.COLS(4), .ROWS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready), .out_slot(out_slot), .out_x(out_x), .out_y(out_y)
`ifdef CARD_POS_HIT_EN
      , .ptr_x(ptr_x), .ptr_y(ptr_y), .hit_valid(hit_valid), .hit_slot(hit_slot)
`endif
   );

   card_pos_sweep #(.COLS(2), .ROWS(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_slot(out_slot2), .out_x(out_x2), .out_y(out_y2)
`ifdef CARD_POS_HIT_EN
      , .ptr_x(ptr_x2), .ptr_y(ptr_y2), .hit_valid(hit_valid2), .hit_slot(hit_slot2)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Expected beats from the column-major geometry: first n beats of a cols x rows sweep.
   task automatic push_sweep(input int which, input int cols, input int rows, input int n);
      beat_t b;
      for (int c = 0; c < cols; c++) begin
         for (int r = 0; r < rows; r++) begin
            b.slot = c * rows + r + 1;
            b.x    = 60 + 100 * c;
            b.y    = 121 + 100 * r;
            if (b.slot <= n) begin
               if (which == 1) exp_q.push_back(b);
               else exp2_q.push_back(b);
            end
         end
      end
   endtask

   task automatic check_beat(input int which, input logic [4:0] s, input logic [9:0] x, input logic [9:0] y);
      beat_t b;
      if ((which == 1 && exp_q.size() == 0) || (which == 2 && exp2_q.size() == 0)) begin
         total++;
         $display("FAIL unexpected_beat dut%0d: got slot %0d expected none", which, s);
      end else begin
         b = (which == 1) ? exp_q.pop_front() : exp2_q.pop_front();
         chk($sformatf("beat%0d_slot", which), s, b.slot);
         chk($sformatf("beat%0d_x_slot%0d", which, b.slot), x, b.x);
         chk($sformatf("beat%0d_y_slot%0d", which, b.slot), y, b.y);
      end
   endtask

   // Monitors: a transfer is valid && ready, with abort taking priority.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !abort) check_beat(1, out_slot, out_x, out_y);
      if (rst_n && out_valid2 && out_ready2 && !abort2) check_beat(2, out_slot2, out_x2, out_y2);
      if (done) done_cnt++;
      if (done2) done_cnt2++;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_slot(input int s);
      for (int i = 0; i < 64; i++) begin
         if (out_valid && out_slot == 5'(s)) break;
         @(posedge clk); #1;
      end
      chk("wait_slot", out_slot, s);
   endtask

   // Waits for the sweep to end, then checks the one-cycle done pulse.
   task automatic finish_sweep(input string tag);
      for (int i = 0; i < 64; i++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      exp_done++;
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_valid_end"}, out_valid, 0);
      chk({tag, "_done_pulse"}, done, 1);
      @(posedge clk); #1;
      chk({tag, "_done_low"}, done, 0);
      chk({tag, "_done_count"}, done_cnt, exp_done);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      start2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b1;
`ifdef CARD_POS_HIT_EN
      ptr_x = '0; ptr_y = '0; ptr_x2 = '0; ptr_y2 = '0;
`endif
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_slot", out_slot, 0);
      chk("rst_xy", {out_x, out_y}, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: full sweep with ready held high
      push_sweep(1, 4, 4, 16);
      pulse_start();
      chk("t1_busy", busy, 1);
      chk("t1_first_slot", out_slot, 1);
      chk("t1_first_x", out_x, 60);
      chk("t1_first_y", out_y, 121);
      finish_sweep("t1");

      // 2: backpressure on beat 7
      push_sweep(1, 4, 4, 16);
      pulse_start();
      wait_slot(7);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t2_hold_valid", out_valid, 1);
         chk("t2_hold_slot", out_slot, 7);
         chk("t2_hold_x", out_x, 160);
         chk("t2_hold_y", out_y, 321);
      end
      out_ready = 1'b1;
      finish_sweep("t2");

      // 3: abort during beat 9, then restart
      push_sweep(1, 4, 4, 8);
      pulse_start();
      wait_slot(9);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t3_valid", out_valid, 0);
      chk("t3_busy", busy, 0);
      chk("t3_done", done, 0);
      @(posedge clk); #1;
      chk("t3_done_count", done_cnt, exp_done);
      chk("t3_queue_empty", exp_q.size(), 0);
      push_sweep(1, 4, 4, 16);
      pulse_start();
      chk("t3_restart_slot", out_slot, 1);
      finish_sweep("t3r");

      // 4: asynchronous reset at beat 4
      push_sweep(1, 4, 4, 3);
      pulse_start();
      wait_slot(4);
      rst_n = 1'b0;
      #1;
      chk("t4_valid", out_valid, 0);
      chk("t4_busy", busy, 0);
      chk("t4_slot", out_slot, 0);
      chk("t4_xy", {out_x, out_y}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t4_no_done", done_cnt, exp_done);
      chk("t4_queue_empty", exp_q.size(), 0);
      push_sweep(1, 4, 4, 16);
      pulse_start();
      finish_sweep("t4r");

      // 5: 2x3 board, start re-asserted mid-sweep
      push_sweep(2, 2, 3, 6);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid2 && out_slot2 == 5'd3) break;
         @(posedge clk); #1;
      end
      chk("t5_slot3", out_slot2, 3);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!busy2) break;
         @(posedge clk); #1;
      end
      chk("t5_busy_end", busy2, 0);
      chk("t5_done_pulse", done2, 1);
      @(posedge clk); #1;
      chk("t5_done_count", done_cnt2, 1);
      chk("t5_queue_empty", exp2_q.size(), 0);

`ifdef CARD_POS_HIT_EN
      // 6: pointer hit test
      ptr_x = 10'd170; ptr_y = 10'd230;
      push_sweep(1, 4, 4, 16);
      pulse_start();
      finish_sweep("t6a");
      chk("t6_hit_valid", hit_valid, 1);
      chk("t6_hit_slot", hit_slot, 6);
      ptr_x = 10'd150; ptr_y = 10'd230;
      push_sweep(1, 4, 4, 16);
      pulse_start();
      chk("t6_clear_valid", hit_valid, 0);
      finish_sweep("t6b");
      chk("t6_miss_valid", hit_valid, 0);
      chk("t6_miss_slot", hit_slot, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
